// File: rtl/matrix_vec_mac_if.sv
// Operand, result and handshake bundle for matrix_vec_mac.
// Elements are indexed [row][col][bit] on the matrix and [idx][bit] on the vectors.
interface matrix_vec_mac_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
);
  logic                                 startMult;
  logic                                 mode;
  logic [0:ROWS-1][0:COLS-1][WIDTH-1:0] A;
  logic [0:COLS-1][WIDTH-1:0]           B;
  logic [0:ROWS-1][WIDTH-1:0]           C;
  logic [0:ROWS-1][WIDTH-1:0]           Res;
  logic                                 busy;
  logic                                 endMult;
  logic                                 ovf;

  modport master (
    output startMult, mode, A, B, C,
    input  Res, busy, endMult, ovf
  );

  modport slave (
    input  startMult, mode, A, B, C,
    output Res, busy, endMult, ovf
  );
endinterface

// File: rtl/matrix_vec_mac.sv
// Fixed-point matrix-vector multiply-accumulate: one column per cycle,
// all rows in parallel, then round, saturate and register the result.
module matrix_vec_mac #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int FRAC  = 0
) (
  input logic             clk,
  input logic             rst_n,
  matrix_vec_mac_if.slave bus
);
  localparam int ACCW = 2 * WIDTH + $clog2(COLS) + 1;
  localparam int SW   = ACCW + 2;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic signed [SW-1:0] RND  = (SW'(1) << FRAC) >> 1;
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                               state;
  logic                                 start_prev;
  logic [CW-1:0]                        col;
  logic                                 mode_reg;
  logic [0:ROWS-1][0:COLS-1][WIDTH-1:0] a_reg;
  logic [0:COLS-1][WIDTH-1:0]           b_reg;
  logic [0:ROWS-1][WIDTH-1:0]           c_reg;
  logic signed [ACCW-1:0]               acc [ROWS];

  logic signed [2*WIDTH-1:0] prod [ROWS];
  logic signed [SW-1:0]      sum  [ROWS];
  logic signed [SW-1:0]      shf  [ROWS];
  logic [WIDTH-1:0]          sat_val [ROWS];
  logic [ROWS-1:0]           sat_hit;
  logic                      rise;

  assign rise     = bus.startMult & ~start_prev;
  assign bus.busy = (state != IDLE);

  always_comb begin
    sat_hit = '0;
    for (int r = 0; r < ROWS; r++) begin
      prod[r] = (2*WIDTH)'($signed(a_reg[r][col]))
              * (2*WIDTH)'($signed(b_reg[col]));
      sum[r] = SW'(acc[r]) + RND;
      if (mode_reg)
        sum[r] = sum[r] + (SW'($signed(c_reg[r])) <<< FRAC);
      shf[r] = sum[r] >>> FRAC;
      sat_val[r] = shf[r][WIDTH-1:0];
      if (shf[r] > MAXV) begin
        sat_val[r] = MAXV[WIDTH-1:0];
        sat_hit[r] = 1'b1;
      end else if (shf[r] < MINV) begin
        sat_val[r] = MINV[WIDTH-1:0];
        sat_hit[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_prev  <= 1'b0;
      col         <= '0;
      mode_reg    <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      for (int r = 0; r < ROWS; r++)
        acc[r] <= '0;
      bus.Res     <= '0;
      bus.endMult <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      start_prev  <= bus.startMult;
      bus.endMult <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            c_reg    <= bus.C;
            mode_reg <= bus.mode;
            for (int r = 0; r < ROWS; r++)
              acc[r] <= '0;
            col      <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          for (int r = 0; r < ROWS; r++)
            acc[r] <= acc[r] + ACCW'(prod[r]);
          if (col == CW'(COLS - 1)) begin
            col   <= '0;
            state <= OUT;
          end else begin
            col <= col + 1'b1;
          end
        end
        OUT: begin
          for (int r = 0; r < ROWS; r++)
            bus.Res[r] <= sat_val[r];
          bus.ovf     <= |sat_hit;
          bus.endMult <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_vec_mac.sv
// Directed bench for matrix_vec_mac: integer instance (FRAC=0)
// and fixed-point instance (FRAC=8) sharing clock and reset.
module tb_matrix_vec_mac;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  typedef logic [0:3][15:0]       vec_t;
  typedef logic [0:3][0:3][15:0]  mat_t;

  localparam mat_t A_BASIC = {
    16'd7, 16'd3, 16'd9, 16'd6,
    16'd1, 16'd6, 16'd5, 16'd2,
    16'd2, 16'd4, 16'd3, 16'd3,
    16'd3, 16'd5, 16'd5, 16'd7};
  localparam vec_t B_BASIC = {16'd3, 16'd5, 16'd7, 16'd5};

  matrix_vec_mac_if #(.WIDTH(16), .ROWS(4), .COLS(4)) if0 ();
  matrix_vec_mac_if #(.WIDTH(16), .ROWS(4), .COLS(4)) if8 ();

  matrix_vec_mac #(.WIDTH(16), .ROWS(4), .COLS(4), .FRAC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  matrix_vec_mac #(.WIDTH(16), .ROWS(4), .COLS(4), .FRAC(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));

  task automatic go0(input int rerise, input bit scramble,
                     output int at, output int pulses);
    at = -1;
    pulses = 0;
    if0.startMult = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) if0.startMult = 1'b0;
      if (i == rerise) if0.startMult = 1'b1;
      if (scramble && i == 1) begin
        if0.A = '1;
        if0.B = '1;
        if0.C = '0;
        if0.mode = ~if0.mode;
      end
      if (if0.endMult) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    if0.startMult = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic go8(output int at);
    at = -1;
    if8.startMult = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) if8.startMult = 1'b0;
      if (if8.endMult && at < 0) at = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.startMult = 0; if0.mode = 0;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.C = '0;
    if8.startMult = 0; if8.mode = 0;
    if8.A = '0; if8.B = '0; if8.C = '0;
    #1;
    total++;
    if (if0.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy0: got %b want 0", if0.busy);
    end
    total++;
    if (if0.Res !== '0) begin
      bad++; $display("FAIL reset_res0: got %h want 0", if0.Res);
    end
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (if0.endMult !== 1'b0 || if0.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags0: got end=%b ovf=%b want 0 0",
               if0.endMult, if0.ovf);
    end
    total++;
    if (if8.busy !== 1'b0 || if8.Res !== '0) begin
      bad++;
      $display("FAIL reset_dut8: got busy=%b res=%h want 0 0",
               if8.busy, if8.Res);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (if0.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b want 0", if0.busy);
    end
  endtask

  task automatic test_basic();
    int at = -1;
    int pulses = 0;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.C = '0; if0.mode = 0;
    if0.startMult = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        total++;
        if (if0.busy !== 1'b1) begin
          bad++; $display("FAIL basic_busy_on: got %b want 1", if0.busy);
        end
      end
      if (i == 4) if0.startMult = 1'b0;
      if (i == 5) begin
        total++;
        if (if0.busy !== 1'b0) begin
          bad++; $display("FAIL basic_busy_off: got %b want 0", if0.busy);
        end
      end
      if (if0.endMult) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    total++;
    if (at !== 5) begin
      bad++; $display("FAIL basic_latency: got %0d want 5", at);
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL basic_pulses: got %0d want 1", pulses);
    end
    total++;
    if (if0.Res !== {16'd129, 16'd78, 16'd62, 16'd104}) begin
      bad++; $display("FAIL basic_res: got %h want 0081004e003e0068",
                      if0.Res);
    end
    total++;
    if (if0.ovf !== 1'b0) begin
      bad++; $display("FAIL basic_ovf: got %b want 0", if0.ovf);
    end
  endtask

  task automatic test_accumulate();
    int at, pulses;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.mode = 1;
    if0.C = {4{16'd100}};
    go0(-1, 1'b1, at, pulses);
    total++;
    if (if0.Res !== {16'd229, 16'd178, 16'd162, 16'd204}) begin
      bad++; $display("FAIL accum_res: got %h want 00e500b200a200cc",
                      if0.Res);
    end
    total++;
    if (at !== 5 || pulses !== 1) begin
      bad++; $display("FAIL accum_timing: got at=%0d n=%0d want 5 1",
                      at, pulses);
    end
  endtask

  task automatic test_saturation();
    int at, pulses;
    if0.A = {16{16'h7fff}}; if0.B = {4{16'h7fff}};
    if0.C = '0; if0.mode = 0;
    go0(-1, 1'b0, at, pulses);
    total++;
    if (if0.Res !== {4{16'h7fff}}) begin
      bad++; $display("FAIL sat_res: got %h want 7fff7fff7fff7fff",
                      if0.Res);
    end
    total++;
    if (if0.ovf !== 1'b1) begin
      bad++; $display("FAIL sat_ovf: got %b want 1", if0.ovf);
    end
  endtask

  task automatic test_signed();
    int at, pulses;
    mat_t m = '0;
    m[0] = {4{16'hffff}};
    if0.A = m; if0.B = {4{16'd5}}; if0.C = '0; if0.mode = 0;
    go0(-1, 1'b0, at, pulses);
    total++;
    if (if0.Res !== {16'hffec, 16'h0, 16'h0, 16'h0}) begin
      bad++; $display("FAIL signed_res: got %h want ffec000000000000",
                      if0.Res);
    end
    total++;
    if (if0.ovf !== 1'b0) begin
      bad++; $display("FAIL signed_ovf: got %b want 0", if0.ovf);
    end
  endtask

  task automatic test_rounding();
    int at;
    mat_t m = '0;
    vec_t b = '0;
    m[0][0] = 16'h0180;
    b[0] = 16'h0180;
    if8.A = m; if8.B = b; if8.C = '0; if8.mode = 0;
    go8(at);
    total++;
    if (if8.Res !== {16'h0240, 16'h0, 16'h0, 16'h0} || at !== 5) begin
      bad++; $display("FAIL round_res: got %h at=%0d want 0240... at=5",
                      if8.Res, at);
    end
    m[0][0] = 16'h0001;
    b[0] = 16'h0080;
    if8.A = m; if8.B = b;
    go8(at);
    total++;
    if (if8.Res[0] !== 16'h0001) begin
      bad++; $display("FAIL tie_pos: got %h want 0001", if8.Res[0]);
    end
    m[0][0] = 16'hffff;
    if8.A = m;
    go8(at);
    total++;
    if (if8.Res[0] !== 16'h0000) begin
      bad++; $display("FAIL tie_neg: got %h want 0000", if8.Res[0]);
    end
    total++;
    if (if8.ovf !== 1'b0) begin
      bad++; $display("FAIL tie_ovf: got %b want 0", if8.ovf);
    end
  endtask

  task automatic test_mid_rise();
    int at, pulses;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.C = '0; if0.mode = 0;
    go0(2, 1'b0, at, pulses);
    total++;
    if (pulses !== 1 || at !== 5) begin
      bad++; $display("FAIL mid_rise: got n=%0d at=%0d want 1 5",
                      pulses, at);
    end
    total++;
    if (if0.Res !== {16'd129, 16'd78, 16'd62, 16'd104}) begin
      bad++; $display("FAIL mid_rise_res: got %h want 0081004e003e0068",
                      if0.Res);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.mode = 1;
    if0.C = {4{16'd100}};
    if0.startMult = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) if0.startMult = 1'b0;
      if (i == 2) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (if0.busy !== 1'b0) begin
          bad++; $display("FAIL abort_busy: got %b want 0", if0.busy);
        end
        total++;
        if (if0.Res !== '0) begin
          bad++; $display("FAIL abort_res: got %h want 0", if0.Res);
        end
      end
      if (i == 4) rst_n = 1'b1;
      if (if0.endMult) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL abort_pulse: got %0d want 0", pulses);
    end
  endtask

  task automatic test_start_at_reset();
    int at = -1;
    rst_n = 1'b0;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.C = '0; if0.mode = 0;
    if0.startMult = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if0.endMult && at < 0) at = i;
    end
    if0.startMult = 1'b0;
    @(posedge clk); #1;
    total++;
    if (at !== 5) begin
      bad++; $display("FAIL start_at_reset: got at=%0d want 5", at);
    end
    total++;
    if (if0.Res !== {16'd129, 16'd78, 16'd62, 16'd104}) begin
      bad++; $display("FAIL start_at_reset_res: got %h want 0081004e003e0068",
                      if0.Res);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    if0.A = A_BASIC; if0.B = B_BASIC; if0.C = '0; if0.mode = 0;
    if0.startMult = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 0) if0.startMult = 1'b0;
      if (if0.endMult) pulses++;
      if (i == 5) begin
        total++;
        if (if0.endMult !== 1'b1 ||
            if0.Res !== {16'd129, 16'd78, 16'd62, 16'd104}) begin
          bad++; $display("FAIL b2b_first: got end=%b res=%h want 1 0081004e003e0068",
                          if0.endMult, if0.Res);
        end
        if0.B = {4{16'd1}};
        if0.startMult = 1'b1;
      end
      if (i == 6) begin
        total++;
        if (if0.busy !== 1'b1) begin
          bad++; $display("FAIL b2b_busy: got %b want 1", if0.busy);
        end
        if0.startMult = 1'b0;
      end
      if (i == 10) begin
        total++;
        if (if0.endMult !== 1'b0) begin
          bad++; $display("FAIL b2b_early: got %b want 0", if0.endMult);
        end
      end
      if (i == 11) begin
        total++;
        if (if0.endMult !== 1'b1 ||
            if0.Res !== {16'd25, 16'd14, 16'd12, 16'd20}) begin
          bad++; $display("FAIL b2b_second: got end=%b res=%h want 1 0019000e000c0014",
                          if0.endMult, if0.Res);
        end
      end
    end
    total++;
    if (pulses !== 2) begin
      bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_saturation();
    test_signed();
    test_rounding();
    test_mid_rise();
    test_reset_abort();
    test_start_at_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_vec_mac.md
MATRIX_VEC_MAC -- requirements
Module: matrix_vec_mac

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the element width (two's-complement signed) of A, B, C and Res.
REQ-002 Parameter ROWS, default 4, SHALL set the row count of A and the length of C and Res.
REQ-003 Parameter COLS, default 4, SHALL set the column count of A and the length of B; legal range 1..64.
REQ-004 Parameter FRAC, default 0, SHALL set the fractional bits of the fixed-point format; legal range 0..WIDTH-1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 startMult  input  1  SHALL request an operation on its 0->1 transition.
REQ-008 mode  input  1  SHALL select the operation: 0 gives Res=A*B; 1 gives Res=A*B+C.
REQ-009 A  input  [WIDTH-1:0][0:ROWS-1][0:COLS-1]  SHALL carry the matrix operand.
REQ-010 B  input  [WIDTH-1:0][0:COLS-1]  SHALL carry the vector operand.
REQ-011 C  input  [WIDTH-1:0][0:ROWS-1]  SHALL carry the accumulate vector; it is ignored when mode=0.
REQ-012 Res  output  [WIDTH-1:0][0:ROWS-1]  SHALL carry the registered result vector.
REQ-013 busy  output  1  SHALL be high while an operation is in progress.
REQ-014 endMult  output  1  SHALL be a one-cycle completion pulse.
REQ-015 ovf  output  1  SHALL be high when at least one Res element saturated in the last operation.

Function
REQ-016 The FSM SHALL have the states IDLE, MAC and OUT; busy SHALL equal (state != IDLE).
REQ-017 A registered startPrev SHALL detect rises; a rise SHALL be startMult=1 while startPrev=0.
REQ-018 In IDLE, a rise SHALL capture A, B, C and mode into internal registers, clear all accumulators, set col=0 and move to MAC.
REQ-019 Holding startMult high SHALL NOT retrigger an operation; a rise while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 In MAC, each cycle SHALL update acc[r] += Areg[r][col]*Breg[col] for all ROWS rows in parallel, then increment col.
REQ-021 When col=COLS-1, MAC SHALL move to OUT.
REQ-022 Products SHALL be signed 2*WIDTH bits; accumulators SHALL be 2*WIDTH+clog2(COLS)+1 bits, so they never wrap.
REQ-023 In OUT, when mode=1, sign-extended Creg[r]<<<FRAC SHALL be added to acc[r].
REQ-024 In OUT, the sum SHALL then be rounded half-up by adding 1<<(FRAC-1) when FRAC>0, followed by an arithmetic shift right by FRAC.
REQ-025 In OUT, the shifted value SHALL be saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-026 The OUT edge SHALL write Res, write ovf (OR over rows of the saturation events), pulse endMult for exactly one cycle and return to IDLE.
REQ-027 Latency: a rise sampled at edge k SHALL give busy=1 after edge k, Res valid and endMult=1 after edge k+COLS+1, and busy=0 in that same cycle.
REQ-028 A rise sampled in the cycle in which endMult=1 SHALL be accepted, giving back-to-back operations with a COLS+2 cycle period.
REQ-029 Res and ovf SHALL hold their values until the next OUT edge; changes to A, B, C or mode after capture SHALL NOT affect the running operation.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, busy=0, endMult=0, ovf=0, Res=all zeros, col=0, accumulators=0 and startPrev=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no endMult pulse.
REQ-032 If startMult=1 when rst_n releases, the first clock edge SHALL treat it as a rise and start an operation.

Verification
REQ-033 Basic (FRAC=0, mode=0): A rows {7,3,9,6},{1,6,5,2},{2,4,3,3},{3,5,5,7}; B={3,5,7,5}; single rise -> Res={129,78,62,104}, ovf=0, endMult exactly 5 cycles after the start edge, one pulse only despite startMult held high for 5 cycles.
REQ-034 Accumulate: same operands, mode=1, C={100,100,100,100} -> Res={229,178,162,204}.
REQ-035 Signed and saturation (FRAC=0): row 0 all 16'hFFFF with B all 5 -> Res[0]=16'hFFEC; all A and B elements 16'h7FFF -> every Res=16'h7FFF and ovf=1.
REQ-036 Rounding (FRAC=8): A[0][0]=16'h0180, B[0]=16'h0180, others 0 -> Res[0]=16'h0240.
REQ-037 Rounding tie (FRAC=8): A[0][0]=16'h0001, B[0]=16'h0080 -> Res[0]=16'h0001; A[0][0]=16'hFFFF with the same B -> Res[0]=16'h0000.
REQ-038 Control: a rise mid-MAC is ignored (one endMult only); rst_n pulsed low 2 cycles after start -> busy=0 and Res=0 at once with no endMult; a rise in the endMult cycle starts the next operation back-to-back.
